uart_rx_byte: RTL and testbench

Serial-to-parallel UART receiver (8N1, LSB first) that turns the asynchronous `rx` line into single-cycle byte strobes. It sits directly upstream of the command string recogniser. Its `recv_valid`/`recv_data` outputs feed that recogniser's inputs of the same name. Each accepted byte produces exactly one `recv_valid` pulse. Framing errors are flagged and never delivered as data.

---
 rtl/uart_rx_byte.sv | 139 +++++++++++++
 tb/tb_uart_rx_byte.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
// Serial-to-parallel UART receiver, 8N1, LSB first. Produces a one-cycle
// strobe per accepted byte and a one-cycle strobe on a framing error.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   rx         in   serial line, idle high, asynchronous to clk
//   recv_valid out  one-cycle strobe, recv_data holds a new byte
//   recv_data  out  last good byte, held until the next recv_valid
//   frame_err  out  one-cycle strobe when the stop bit samples low
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for a falling edge on the synchronised line
// START   | timing to the start-bit midpoint to confirm it is still low
// DATA    | sampling 8 data bits at their midpoints, LSB first
// STOP    | sampling the stop bit at its midpoint
// BREAK   | stop bit was low; wait for the line to return high
module uart_rx_byte #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       recv_valid,
    output logic [7:0] recv_data,
    output logic       frame_err
);

    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic          rx_s1;
    logic          rx_s2;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= 3'd0;
            shreg      <= 8'h00;
            recv_data  <= 8'h00;
            recv_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            recv_valid <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                S_IDLE: begin
                    // rx_s2 is the older sample, so 1 -> 0 here is a falling edge
                    if (rx_s2 && !rx_s1) begin
                        cnt   <= '0;
                        state <= S_START;
                    end
                end

                S_START: begin
                    if (cnt == CNT_HALF) begin
                        if (!rx_s1) begin
                            cnt     <= '0;
                            bit_idx <= 3'd0;
                            state   <= S_DATA;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_s1, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            bit_idx <= 3'd0;
                            state   <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                S_STOP: begin
                    // Leaving at the stop midpoint leaves half a bit to catch
                    // a back-to-back start edge.
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s1) begin
                            recv_data  <= shreg;
                            recv_valid <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                S_BREAK: begin
                    if (rx_s1) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Testbench for uart_rx_byte: directed scenarios plus random frames.
// Stimulus pushes the expected strobe (kind, byte, cycle) into a queue;
// a negedge monitor pops and compares whenever the DUT strobes.
module tb_uart_rx_byte;

    localparam int CLK_FREQ = 16;
    localparam int BAUD     = 1;
    localparam int CPB      = 16;
    localparam int HALF     = 8;
    // Start bit driven just after posedge n: synchroniser exposes the edge
    // after posedge n+1 (cycle E), stop sample at E+HALF+9*CPB, strobe the
    // cycle after that, i.e. visible after posedge n + 2 + HALF + 9*CPB.
    localparam int LAT = 2 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       recv_valid;
    logic [7:0] recv_data;
    logic       frame_err;

    uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .recv_valid (recv_valid),
        .recv_data  (recv_data),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         when;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] last_good  = 8'h00;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("rst_recv_valid", int'(recv_valid), 0);
            check("rst_frame_err", int'(frame_err), 0);
            check("rst_recv_data", int'(recv_data), 0);
            last_good = 8'h00;
        end else begin
            check("strobes_exclusive", int'(recv_valid & frame_err), 0);
            if (recv_valid || frame_err) begin
                check("strobe_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("strobe_kind_ferr", int'(frame_err), int'(e.is_err));
                    check("strobe_cycle", cyc, e.when);
                    if (!e.is_err) begin
                        check("recv_data", int'(recv_data), int'(e.data));
                        last_good = e.data;
                    end
                end
            end
            check("recv_data_hold", int'(recv_data), int'(last_good));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    // Drive one frame; the caller must be aligned 1 time unit after a posedge.
    task automatic send(input logic [7:0] d, input bit stop_bit, input int low_after,
                        input bit expect_it);
        exp_t x;
        if (expect_it) begin
            x.is_err = !stop_bit;
            x.data   = d;
            x.when   = cyc + LAT;
            sb.push_back(x);
        end
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) tick();
        end
        rx = stop_bit;
        repeat (CPB) tick();
        if (!stop_bit) begin
            repeat (low_after) tick();
            rx = 1'b1;
        end
    endtask

    logic [7:0] msg [6] = '{8'h73, 8'h74, 8'h61, 8'h72, 8'h74, 8'h0D};

    initial begin
        logic [7:0] d;
        bit         bad;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        idle(20);

        // single byte
        send(8'h73, 1'b1, 0, 1'b1);
        idle(30);

        // back-to-back "start\r"
        for (int i = 0; i < 6; i++) send(msg[i], 1'b1, 0, 1'b1);
        idle(30);

        // glitch shorter than half a bit, then a real frame
        rx = 1'b0;
        repeat (4) tick();
        idle(40);
        send(8'h55, 1'b1, 0, 1'b1);
        idle(30);

        // framing error from a freshly reset receiver, line held low after
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        idle(10);
        send(8'h3C, 1'b0, 50, 1'b1);
        idle(30);
        send(8'hC3, 1'b1, 0, 1'b1);
        idle(30);

        // reset during data bit 3 of 0xFF; no strobe for that frame
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 3; i++) begin
            rx = 1'b1;
            repeat (CPB) tick();
        end
        rx = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (CPB - 7) tick();
        for (int i = 4; i < 9; i++) begin
            rx = 1'b1;
            repeat (CPB) tick();
        end
        idle(30);
        send(8'hA5, 1'b1, 0, 1'b1);
        idle(30);

        // random frames, some with a low stop bit, random idle gaps
        for (int k = 0; k < 40; k++) begin
            d   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 7) == 0);
            if (bad) begin
                send(d, 1'b0, $urandom_range(0, 60), 1'b1);
                idle($urandom_range(4, 20));
            end else begin
                send(d, 1'b1, 0, 1'b1);
                idle($urandom_range(0, 20));
            end
        end

        idle(LAT + 20);
        check("all_expected_seen", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
